matrix_operand_sequencer: RTL

//  Successor to the single-config row/column fetcher. Streams the operand pairs of C = A x B in
//  (i, j, k) order from A/B operand RAMs to the multiply-accumulate stage over a valid/ready link.

---
 rtl/matrix_operand_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/matrix_operand_sequencer.sv
// Streams A/B operand pairs of C = A x B in (i, j, k) order to the MAC stage.
// A 2-entry skid FIFO absorbs the one-cycle RAM latency under backpressure.
module matrix_operand_sequencer #(
    parameter int A_ROWS = 8,
    parameter int INNER  = 8,
    parameter int B_COLS = 8,
    parameter int DATA_W = 32,
    localparam int ADDR_A_W = (A_ROWS * INNER > 1) ? $clog2(A_ROWS * INNER) : 1,
    localparam int ADDR_B_W = (INNER * B_COLS > 1) ? $clog2(INNER * B_COLS) : 1,
    localparam int ROW_W    = (A_ROWS > 1) ? $clog2(A_ROWS) : 1,
    localparam int COL_W    = (B_COLS > 1) ? $clog2(B_COLS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                b_transposed,
    output logic                busy,
    output logic                done,
    output logic                rd_en_a,
    output logic [ADDR_A_W-1:0] rd_address_a,
    input  logic [DATA_W-1:0]   read_data_a,
    output logic                rd_en_b,
    output logic [ADDR_B_W-1:0] rd_address_b,
    input  logic [DATA_W-1:0]   read_data_b,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [DATA_W-1:0]   op_a,
    output logic [DATA_W-1:0]   op_b,
    output logic                op_last,
    output logic [ROW_W-1:0]    op_row,
    output logic [COL_W-1:0]    op_col
);

    localparam int K_W = (INNER > 1) ? $clog2(INNER) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [K_W-1:0]      k_q, k_n;
    logic [COL_W-1:0]    j_q, j_n;
    logic [ROW_W-1:0]    i_q, i_n;
    logic                k_end, j_end, i_end;
    logic                bt_q;
    logic                issue;
    logic                in_flight;
    logic                tag_last;
    logic [ROW_W-1:0]    tag_row;
    logic [COL_W-1:0]    tag_col;
    logic [ADDR_A_W-1:0] addr_a_n;
    logic [ADDR_B_W-1:0] addr_b_n;

    logic [DATA_W-1:0] fifo_a [2];
    logic [DATA_W-1:0] fifo_b [2];
    logic              fifo_l [2];
    logic [ROW_W-1:0]  fifo_r [2];
    logic [COL_W-1:0]  fifo_c [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;
    logic              push, pop;
    logic [2:0]        occ;

    assign k_end = (k_q == K_W'(INNER - 1));
    assign j_end = (j_q == COL_W'(B_COLS - 1));
    assign i_end = (i_q == ROW_W'(A_ROWS - 1));

    assign push = in_flight;
    assign pop  = op_valid & op_ready;
    // Occupancy after this cycle's pop, including the read returning now.
    assign occ  = {1'b0, count} + {2'b0, in_flight} - {2'b0, pop};

    always_comb begin
        k_n = k_q + 1'b1;
        j_n = j_q;
        i_n = i_q;
        if (k_end) begin
            k_n = '0;
            j_n = j_q + 1'b1;
            if (j_end) begin
                j_n = '0;
                i_n = i_q + 1'b1;
            end
        end
    end

    always_comb begin
        addr_a_n = ADDR_A_W'(int'(i_n) * INNER + int'(k_n));
        if (bt_q) begin
            addr_b_n = ADDR_B_W'(int'(j_n) * INNER + int'(k_n));
        end else begin
            addr_b_n = ADDR_B_W'(int'(k_n) * B_COLS + int'(j_n));
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (occ < 3'd2) begin
                    issue = 1'b1;
                    if (k_end && j_end && i_end) state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!in_flight && occ == 3'd0) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_en_a = issue;
    assign rd_en_b = issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q          <= '0;
            j_q          <= '0;
            i_q          <= '0;
            bt_q         <= 1'b0;
            rd_address_a <= '0;
            rd_address_b <= '0;
            in_flight    <= 1'b0;
            tag_last     <= 1'b0;
            tag_row      <= '0;
            tag_col      <= '0;
        end else begin
            in_flight <= issue;
            if (state_q == IDLE && start) begin
                k_q          <= '0;
                j_q          <= '0;
                i_q          <= '0;
                bt_q         <= b_transposed;
                rd_address_a <= '0;
                rd_address_b <= '0;
            end else if (issue) begin
                k_q          <= k_n;
                j_q          <= j_n;
                i_q          <= i_n;
                rd_address_a <= addr_a_n;
                rd_address_b <= addr_b_n;
                tag_last     <= k_end;
                tag_row      <= i_q;
                tag_col      <= j_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int n = 0; n < 2; n++) begin
                fifo_a[n] <= '0;
                fifo_b[n] <= '0;
                fifo_l[n] <= 1'b0;
                fifo_r[n] <= '0;
                fifo_c[n] <= '0;
            end
        end else begin
            if (push) begin
                fifo_a[wr_ptr] <= read_data_a;
                fifo_b[wr_ptr] <= read_data_b;
                fifo_l[wr_ptr] <= tag_last;
                fifo_r[wr_ptr] <= tag_row;
                fifo_c[wr_ptr] <= tag_col;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign op_valid = (count != 2'd0);
    assign op_a     = fifo_a[rd_ptr];
    assign op_b     = fifo_b[rd_ptr];
    assign op_last  = fifo_l[rd_ptr];
    assign op_row   = fifo_r[rd_ptr];
    assign op_col   = fifo_c[rd_ptr];

endmodule
